// File: rtl/ddr_sched_pkg.sv
// Shared types and default constants for the DDR write scheduler.
package ddr_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        CAP,
        WR
    } state_e;

    localparam int          DEF_REQ_NUM       = 4;
    localparam int          DEF_DATA_WIDTH    = 64;
    localparam int          DEF_ADDR_WIDTH    = 32;
    localparam int          DEF_BURST_LEN     = 16;
    localparam int          DEF_REGION_WORDS  = 18816;
    localparam logic [31:0] DEF_REGION_STRIDE = 32'h0004_0000;
    localparam logic [31:0] DEF_BASE_ADDR     = 32'h0000_0000;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ddr_wr_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter; search starts just after the last grant.
module rr_arbiter
    import ddr_sched_pkg::*;
#(
    parameter int N  = DEF_REQ_NUM,
    parameter int IW = clog2_min1(DEF_REQ_NUM)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [N-1:0]  gnt_o
);

    int idx;

    // Walk farthest-to-nearest so the nearest requester overwrites the rest.
    always_comb begin
        gnt_o = '0;
        idx   = 0;
        for (int k = N; k >= 1; k--) begin
            idx = (int'(last_i) + k) % N;
            if (req_i[idx]) begin
                gnt_o      = '0;
                gnt_o[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ddr_wr_scheduler.sv
// Drains conv-layer output FIFOs into per-requester DDR frame regions,
// one word per RD/CAP/WR round trip, BURST_LEN words per grant.
module ddr_wr_scheduler
    import ddr_sched_pkg::*;
#(
    parameter int          REQ_NUM       = DEF_REQ_NUM,
    parameter int          DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int          ADDR_WIDTH    = DEF_ADDR_WIDTH,
    parameter int          BURST_LEN     = DEF_BURST_LEN,
    parameter int          REGION_WORDS  = DEF_REGION_WORDS,
    parameter logic [31:0] REGION_STRIDE = DEF_REGION_STRIDE,
    parameter logic [31:0] BASE_ADDR     = DEF_BASE_ADDR
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [REQ_NUM-1:0]            fifo_afull_i,
    output logic [REQ_NUM-1:0]            fifo_rd_o,
    input  logic [REQ_NUM*DATA_WIDTH-1:0] fifo_q_i,
    input  logic [REQ_NUM-1:0]            frame_start_i,
    output logic [ADDR_WIDTH-1:0]         avm_address_o,
    output logic                          avm_write_o,
    output logic [DATA_WIDTH-1:0]         avm_writedata_o,
    input  logic                          avm_waitrequest_i,
    output logic [REQ_NUM-1:0]            grant_o,
    output logic                          busy_o,
    output logic [REQ_NUM-1:0]            frame_done_o
);

    localparam int IW  = clog2_min1(REQ_NUM);
    localparam int OW  = clog2_min1(REGION_WORDS);
    localparam int CW  = clog2_min1(BURST_LEN);
    localparam int BPW = DATA_WIDTH / 8;

    state_e                  state_q, state_d;
    logic [IW-1:0]           g_q, g_d;
    logic [IW-1:0]           last_q, last_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [OW-1:0]           off_q [REQ_NUM];
    logic [OW-1:0]           off_d [REQ_NUM];
    logic [REQ_NUM-1:0]      rd_q, rd_d;
    logic [REQ_NUM-1:0]      gnt_q, gnt_d;
    logic                    busy_q, busy_d;
    logic                    wr_q, wr_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [REQ_NUM-1:0]      arb_gnt;
    logic [IW-1:0]           arb_idx;
    logic                    acc;

    function automatic logic [ADDR_WIDTH-1:0] word_addr(
        input logic [IW-1:0] g,
        input logic [OW-1:0] off
    );
        return ADDR_WIDTH'(BASE_ADDR)
             + ADDR_WIDTH'(g) * ADDR_WIDTH'(REGION_STRIDE)
             + ADDR_WIDTH'(off) * ADDR_WIDTH'(BPW);
    endfunction

    rr_arbiter #(
        .N  (REQ_NUM),
        .IW (IW)
    ) u_arb (
        .req_i  (fifo_afull_i),
        .last_i (last_q),
        .gnt_o  (arb_gnt)
    );

    always_comb begin
        arb_idx = '0;
        for (int i = 0; i < REQ_NUM; i++)
            if (arb_gnt[i]) arb_idx = IW'(i);
    end

    assign acc = (state_q == WR) && !avm_waitrequest_i;

    // Offsets advance on acceptance; a coincident frame_start wins.
    always_comb begin
        for (int i = 0; i < REQ_NUM; i++) begin
            off_d[i] = off_q[i];
            if (acc && g_q == IW'(i))
                off_d[i] = (off_q[i] == OW'(REGION_WORDS - 1)) ? '0 : off_q[i] + 1'b1;
            if (frame_start_i[i])
                off_d[i] = '0;
        end
    end

    always_comb begin
        frame_done_o = '0;
        if (acc && off_q[g_q] == OW'(REGION_WORDS - 1))
            frame_done_o[g_q] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        rd_d    = '0;
        gnt_d   = gnt_q;
        busy_d  = busy_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                if (|fifo_afull_i) begin
                    g_d     = arb_idx;
                    gnt_d   = arb_gnt;
                    rd_d    = arb_gnt;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = RD;
                end
            end
            RD: state_d = CAP;
            CAP: begin
                data_d  = fifo_q_i[g_q*DATA_WIDTH +: DATA_WIDTH];
                addr_d  = word_addr(g_q, off_q[g_q]);
                wr_d    = 1'b1;
                state_d = WR;
            end
            WR: begin
                if (acc) begin
                    wr_d = 1'b0;
                    if (cnt_q == CW'(BURST_LEN - 1)) begin
                        state_d = IDLE;
                        last_d  = g_q;
                        gnt_d   = '0;
                        busy_d  = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        rd_d    = gnt_q;
                        state_d = RD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            g_q     <= '0;
            last_q  <= IW'(REQ_NUM - 1);
            cnt_q   <= '0;
            rd_q    <= '0;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            for (int i = 0; i < REQ_NUM; i++) off_q[i] <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            for (int i = 0; i < REQ_NUM; i++) off_q[i] <= off_d[i];
        end
    end

    assign fifo_rd_o       = rd_q;
    assign grant_o         = gnt_q;
    assign busy_o          = busy_q;
    assign avm_write_o     = wr_q;
    assign avm_address_o   = addr_q;
    assign avm_writedata_o = data_q;

endmodule

// File: tb/tb_ddr_wr_scheduler.sv
// Directed bench for ddr_wr_scheduler with a show-ahead-off FIFO model.
module tb_ddr_wr_scheduler;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int AW = 32;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    afull = '0;
    logic [N-1:0]    frd;
    logic [N*DW-1:0] fq_bus;
    logic [N-1:0]    fstart = '0;
    logic [AW-1:0]   addr;
    logic            wr;
    logic [DW-1:0]   wdata;
    logic            wreq = 1'b0;
    logic [N-1:0]    gnt;
    logic            busy;
    logic [N-1:0]    fdone;

    ddr_wr_scheduler dut (
        .clk               (clk),
        .reset             (reset),
        .fifo_afull_i      (afull),
        .fifo_rd_o         (frd),
        .fifo_q_i          (fq_bus),
        .frame_start_i     (fstart),
        .avm_address_o     (addr),
        .avm_write_o       (wr),
        .avm_writedata_o   (wdata),
        .avm_waitrequest_i (wreq),
        .grant_o           (gnt),
        .busy_o            (busy),
        .frame_done_o      (fdone)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int viol  = 0;

    int          fcnt [N] = '{default: 0};
    logic [63:0] fq   [N] = '{default: '0};

    logic [31:0] wa_q [$];
    logic [63:0] wd_q [$];
    int          wc_q [$];
    int          rc_q [$];
    int          gq   [$];
    logic [3:0]  fd_q [$];
    int          fdw_q[$];

    logic        prev_busy  = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr  = '0;
    logic [63:0] prev_data  = '0;

    function automatic logic [63:0] pat(input int i, input int n);
        return {8'hA5, 8'(i), 16'h0000, 32'(n)};
    endfunction

    function automatic int oh2idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < N; i++)
            if (frd[i]) begin
                fq[i]   <= pat(i, fcnt[i]);
                fcnt[i] <= fcnt[i] + 1;
            end
    end

    always_comb
        for (int i = 0; i < N; i++) fq_bus[i*DW +: DW] = fq[i];

    always @(negedge clk) begin
        if (reset) begin
            prev_busy  = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (wr && !wreq) begin
                wa_q.push_back(addr);
                wd_q.push_back(wdata);
                wc_q.push_back(cyc);
            end
            if (fdone != '0) begin
                fd_q.push_back(fdone);
                fdw_q.push_back(wa_q.size());
            end
            if (frd != '0) rc_q.push_back(cyc);
            if ($countones(frd) > 1 || (frd != '0 && frd != gnt)) viol++;
            if (busy ? ($countones(gnt) != 1) : (gnt != '0)) viol++;
            if (prev_stall && (!wr || addr != prev_addr || wdata != prev_data)) viol++;
            prev_stall = wr && wreq;
            prev_addr  = addr;
            prev_data  = wdata;
            if (busy && !prev_busy) gq.push_back(oh2idx(gnt));
            prev_busy = busy;
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        wa_q.delete(); wd_q.delete(); wc_q.delete(); rc_q.delete();
        gq.delete(); fd_q.delete(); fdw_q.delete();
        viol = 0;
    endtask

    task automatic wait_busy(input int lim);
        int n = 0;
        do begin @(negedge clk); #1; n++; end while (!busy && n < lim);
        chk("busy_to", busy, 1);
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        do begin @(negedge clk); #1; n++; end while (busy && n < lim);
        chk("idle_to", busy, 0);
    endtask

    task automatic wait_words(input int w, input int lim);
        int n = 0;
        do begin @(negedge clk); #1; n++; end while (wa_q.size() < w && n < lim);
        chk("words_to", wa_q.size() >= w, 1);
    endtask

    initial begin
        int c0, s0, s1, nbad, nb, g0, n;

        #1;
        chk("rst_wr",    wr,    0);
        chk("rst_addr",  addr,  0);
        chk("rst_data",  wdata, 0);
        chk("rst_rd",    frd,   0);
        chk("rst_gnt",   gnt,   0);
        chk("rst_busy",  busy,  0);
        chk("rst_fdone", fdone, 0);

        // single requester burst, afull dropped mid-burst
        do_reset();
        s0 = fcnt[0];
        @(posedge clk); #1;
        afull = 4'b0001;
        c0 = cyc;
        wait_busy(10);
        chk("t1_gnt", gnt, 4'b0001);
        @(posedge clk); #1;
        afull = '0;
        wait_idle(200);
        chk("t1_nw", wa_q.size(), 16);
        chk("t1_rd0", rc_q[0], c0 + 1);
        chk("t1_wr0", wc_q[0], c0 + 3);
        nbad = 0;
        for (int k = 0; k < 16; k++) begin
            if (wa_q[k] != 32'(k * 8)) nbad++;
            if (wd_q[k] != pat(0, s0 + k)) nbad++;
        end
        chk("t1_words", nbad, 0);
        chk("t1_last", wa_q[15], 32'h78);
        nbad = 0;
        for (int k = 1; k < 16; k++) if (rc_q[k] - rc_q[k-1] != 3) nbad++;
        chk("t1_rdgap", nbad, 0);
        repeat (5) @(negedge clk);
        #1;
        chk("t1_idle", {busy, gnt}, 0);
        chk("t1_proto", viol, 0);

        // round robin over all requesters
        do_reset();
        s1 = fcnt[1];
        afull = 4'b1111;
        n = 0;
        do begin @(negedge clk); #1; n++; end while (gq.size() < 5 && n < 2000);
        chk("t2_to", gq.size() >= 5, 1);
        afull = '0;
        wait_idle(200);
        chk("t2_g0", gq[0], 0);
        chk("t2_g1", gq[1], 1);
        chk("t2_g2", gq[2], 2);
        chk("t2_g3", gq[3], 3);
        chk("t2_g4", gq[4], 0);
        chk("t2_nw", wa_q.size(), 80);
        chk("t2_r1a", wa_q[16], 32'h0004_0000);
        chk("t2_r1d", wd_q[16], pat(1, s1));
        chk("t2_r2a", wa_q[32], 32'h0008_0000);
        chk("t2_r0b", wa_q[64], 32'h80);
        chk("t2_proto", viol, 0);

        // stall on word 3
        do_reset();
        s0 = fcnt[0];
        afull = 4'b0001;
        wait_busy(10);
        afull = '0;
        wait_words(3, 100);
        @(posedge clk); #1;
        wreq = 1'b1;
        n = 0; c0 = 0;
        do begin @(negedge clk); #1; c0++; if (wr) n++; end while (n < 5 && c0 < 50);
        @(posedge clk); #1;
        wreq = 1'b0;
        wait_idle(200);
        chk("t3_nw", wa_q.size(), 16);
        chk("t3_nrd", rc_q.size(), 16);
        chk("t3_gap", rc_q[4] - rc_q[3], 8);
        chk("t3_a3", wa_q[3], 32'h18);
        chk("t3_d3", wd_q[3], pat(0, s0 + 3));
        chk("t3_d15", wd_q[15], pat(0, s0 + 15));
        chk("t3_proto", viol, 0);

        // frame_start coincident with acceptance of word 5
        do_reset();
        afull = 4'b0001;
        wait_busy(10);
        afull = '0;
        wait_words(5, 100);
        repeat (3) @(posedge clk);
        #1;
        fstart = 4'b0001;
        @(posedge clk); #1;
        fstart = '0;
        wait_idle(200);
        chk("t5_a5",  wa_q[5],  32'h28);
        chk("t5_a6",  wa_q[6],  32'h0);
        chk("t5_a15", wa_q[15], 32'h48);

        // reset in WR aborts the pending write and restarts at requester 0
        do_reset();
        afull = 4'b0010;
        wait_words(16, 200);
        @(posedge clk); #1;
        wreq = 1'b1;
        n = 0;
        do begin @(negedge clk); #1; n++; end while (!wr && n < 20);
        chk("t6_inwr", wr, 1);
        #1;
        reset = 1'b1;
        #1;
        chk("t6_wr",    wr,    0);
        chk("t6_addr",  addr,  0);
        chk("t6_data",  wdata, 0);
        chk("t6_rd",    frd,   0);
        chk("t6_gnt",   gnt,   0);
        chk("t6_busy",  busy,  0);
        chk("t6_fdone", fdone, 0);
        nb = wa_q.size();
        g0 = gq.size();
        afull = 4'b1111;
        wreq = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        wait_busy(10);
        chk("t6_nowr", nb, 16);
        chk("t6_first", gq[g0], 0);
        afull = '0;
        wait_idle(200);

        // full frame drain on requester 0
        do_reset();
        afull = 4'b0001;
        wait_words(18817, 70000);
        afull = '0;
        wait_idle(200);
        chk("t4_nfd", fd_q.size(), 1);
        chk("t4_fd", fd_q[0], 4'b0001);
        chk("t4_fdw", fdw_q[0], 18816);
        chk("t4_alast", wa_q[18815], 32'h0002_4BF8);
        chk("t4_anext", wa_q[18816], 32'h0);
        chk("t4_proto", viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
